// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer: JK op encoding, sequencer
// states and a next-state helper that mirrors the downstream JK flip-flop.
// The helper is only used when JK_PRED_EN is defined.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

  // Next Q of a JK flip-flop given current Q and the J/K it samples.
  function automatic logic jk_next_q(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Circular command buffer with wrap-around pointers. A push is refused when
// full and a pop when empty; a simultaneous push and pop leaves the count
// unchanged. Storage is not reset: clearing the pointers discards entries.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Write the accepted entry at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands (op + repeat count) and plays each one onto registered
// J/K outputs for rpt+1 cycles, back-to-back with no bubbles, idling at HOLD.
// Optional macro JK_PRED_EN adds q_pred, a model of the downstream flip-flop.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic [CNT_W-1:0]       cmd_rpt,
  output logic                   cmd_ready,
  output logic                   J,
  output logic                   K,
  output logic                   cmd_last,
  output logic                   busy,
`ifdef JK_PRED_EN
  output logic                   q_pred,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  typedef struct packed {
    jk_op_t           op;
    logic [CNT_W-1:0] rpt;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic [CMD_W-1:0] head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  seq_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             j_q;
  logic             k_q;

  assign push_cmd = '{op: jk_op_t'(cmd_op), rpt: cmd_rpt};
  assign head_cmd = cmd_t'(head_bits);

  // Pop whenever the issue slot frees up: idle, or on the final cycle of a command.
  assign pop = !fifo_empty && ((state_q == IDLE) || (cnt_q == '0));

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .pop_i   (pop),
    .din_i   (push_cmd),
    .dout_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q == ISSUE) || !fifo_empty;
  assign cmd_last  = (state_q == ISSUE) && (cnt_q == '0);
  assign J         = j_q;
  assign K         = k_q;

  // Issue FSM: load head into J/K and the repeat counter, count down, chain or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            {j_q, k_q} <= head_cmd.op;
            cnt_q      <= head_cmd.rpt;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (pop) begin
            {j_q, k_q} <= head_cmd.op;
            cnt_q      <= head_cmd.rpt;
          end else begin
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef JK_PRED_EN
  logic q_pred_q;

  // Track the downstream flip-flop from the same registered J/K it samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_pred_q <= 1'b0;
    else     q_pred_q <= jk_next_q(q_pred_q, j_q, k_q);
  end

  assign q_pred = q_pred_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer. The reference model is a timeline:
// each accepted command gets a start edge max(accept+1, previous end+1) and
// occupies rpt+1 cycles; occupancy, busy and ready follow from those times.
// Build with JK_PRED_EN defined to also check q_pred.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_rpt;
  logic             cmd_ready;
  logic             J, K, cmd_last, busy;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef JK_PRED_EN
  logic             q_pred;
`endif

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_rpt    (cmd_rpt),
    .cmd_ready  (cmd_ready),
    .J          (J),
    .K          (K),
    .cmd_last   (cmd_last),
    .busy       (busy),
`ifdef JK_PRED_EN
    .q_pred     (q_pred),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int e;
    int jk;
    bit last;
  } item_t;

  item_t exp_q[$];
  int    acc_q[$];
  int    st_q[$];
  int    en_q[$];
  int    prev_end = -100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Entries held in the FIFO after edge t.
  function automatic int occ_after(input int t);
    int n = 0;
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i] <= t && st_q[i] > t) n++;
    return n;
  endfunction

  // Some command is in its issue window after edge t.
  function automatic bit issuing(input int t);
    for (int i = 0; i < st_q.size(); i++)
      if (st_q[i] <= t && t <= en_q[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ff_next(input bit q, input int jk);
    case (jk)
      0:       return q;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ~q;
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    acc_q.delete();
    st_q.delete();
    en_q.delete();
    prev_end = -100;
  endtask

  // Present inputs for the next edge; record the command if the model says it is taken.
  task automatic drive_cycle(input bit v, input int op, input int rpt, output bit acc);
    int n, st;
    cmd_valid = v;
    cmd_op    = op[1:0];
    cmd_rpt   = rpt[CNT_W-1:0];
    acc = v && (occ_after(cyc) != DEPTH);
    if (acc) begin
      n  = cyc + 1;
      st = (n + 1 > prev_end + 1) ? n + 1 : prev_end + 1;
      acc_q.push_back(n);
      st_q.push_back(st);
      en_q.push_back(st + rpt);
      prev_end = st + rpt;
      for (int k = 0; k <= rpt; k++) exp_q.push_back('{e: st + k, jk: op, last: (k == rpt)});
    end
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic push(input int op, input int rpt);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 100) begin
      drive_cycle(1'b1, op, rpt, acc);
      tries++;
    end
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 0, acc);
  endtask

  // Monitor: each cycle pop the expected J/K if one is due, else expect HOLD.
  initial begin
    item_t it;
    int    t, exp_jk, occ;
    bit    exp_last;
    bit    q_exp = 1'b0;
    forever begin
      @(negedge clk);
      t = cyc;
      exp_jk = 0;
      exp_last = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].e == t) begin
        it = exp_q.pop_front();
        exp_jk = it.jk;
        exp_last = it.last;
      end
      occ = occ_after(t);
      chk("jk", int'({J, K}), exp_jk);
      chk("cmd_last", int'(cmd_last), int'(exp_last));
      chk("fifo_count", int'(fifo_count), occ);
      chk("cmd_ready", int'(cmd_ready), int'(occ != DEPTH));
      chk("busy", int'(busy), int'(issuing(t) || occ != 0));
      if (rst) q_exp = 1'b0;
`ifdef JK_PRED_EN
      chk("q_pred", int'(q_pred), int'(q_exp));
`endif
      q_exp = ff_next(q_exp, exp_jk);
    end
  end

  initial begin
    bit acc;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_rpt = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_jk", int'({J, K}), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 0);
    idle(2);

    // Single SET for 3 cycles.
    push(2, 2);
    idle(6);

    // Back-to-back chain with no bubbles.
    push(2, 0);
    push(3, 3);
    push(1, 1);
    idle(10);

    // Long TOGGLE then overfill the FIFO while busy.
    push(3, 15);
    push(2, 1);
    push(1, 0);
    push(0, 2);
    push(3, 1);
    push(2, 0);
    idle(40);

    // Reset in the middle of a TOGGLE run with two entries queued.
    push(3, 10);
    push(2, 3);
    push(1, 2);
    idle(3);
    rst = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_jk", int'({J, K}), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(12);

    // Predictor sequence: SET, TOGGLE x3, HOLD x2, RESET.
    push(2, 0);
    push(3, 0);
    push(3, 0);
    push(3, 0);
    push(0, 0);
    push(0, 0);
    push(1, 0);
    idle(10);

    // Randomized traffic, frequently saturating the FIFO.
    for (int i = 0; i < 400; i++) begin
      int op, rpt;
      op  = $urandom_range(0, 3);
      rpt = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      drive_cycle(bit'($urandom_range(0, 1)), op, rpt, acc);
    end
    idle(100);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for the JK flip-flop stage: accepts JK commands (op + repeat count) over a valid/ready handshake and buffers them in a small FIFO.
- Plays each command onto registered J/K outputs for rpt+1 consecutive cycles, then continues back-to-back with the next command or idles at HOLD (J=0, K=0).
- J/K connect directly to the JK flip-flop's J/K inputs; both blocks share clk and rst.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 4, width of the repeat count; a command plays for 1..2^CNT_W cycles.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_op  input  2  JK op: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- cmd_rpt  input  CNT_W  extra cycles; the op is driven for cmd_rpt+1 cycles.
- cmd_ready  output  1  FIFO can accept a command.
- J  output  1  registered J to the flip-flop.
- K  output  1  registered K to the flip-flop.
- cmd_last  output  1  high during the final cycle of each command's issue window.
- busy  output  1  state==ISSUE or FIFO non-empty.
- fifo_count  output  $clog2(DEPTH)+1  number of entries held.

Behaviour:
- Reset (async, immediate): J=0, K=0, cmd_last=0, busy=0, fifo_count=0, cmd_ready=1, state=IDLE, cnt=0. FIFO pointers are cleared; buffered entries are discarded.
- Handshake:
  - cmd_ready = (fifo_count != DEPTH), combinational from registered state only.
  - A command is accepted on any edge where cmd_valid && cmd_ready.
  - When the FIFO is full, a push is refused even if a pop occurs the same edge (cmd_ready does not look ahead).
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Simultaneous push and pop when non-empty and non-full: fifo_count is unchanged.
- State machine:
  - IDLE: J/K=00. On an edge with FIFO non-empty (registered count), pop the head, load J/K<=op and cnt<=rpt, go to ISSUE.
  - ISSUE, cnt!=0: cnt<=cnt-1; J/K hold.
  - ISSUE, cnt==0, FIFO non-empty: pop the next command and load it with no bubble cycle; remain in ISSUE.
  - ISSUE, cnt==0, FIFO empty: J/K<=00, go to IDLE.
- Latency:
  - Command accepted on edge E0 into an empty, idle block: J/K show op from E1 until E1+rpt+1.
  - A push to an empty FIFO is not visible to the pop logic on the same edge.
- cmd_last = (state==ISSUE) && (cnt==0); combinational from registers, glitch-free.
- HOLD ops are played like any other op and occupy their full rpt+1 cycles; they produce timed gaps.
- Reset mid-command: J/K drop to 00 immediately. The downstream flip-flop is reset by the same rst, so the pair restarts consistently.

Optional Feature:
- Macro: JK_PRED_EN.
- Defined: adds output q_pred (1 bit), a reference model of the downstream flip-flop.
  - Reset value 0.
  - Updated each edge from the registered J/K: 00 hold, 01 to 0, 10 to 1, 11 invert.
  - q_pred equals the flip-flop's Q every cycle; used for in-system checking.
- Undefined: q_pred port and its logic are absent.

Decomposition:
- Shared package jk_pkg:
  - typedef enum logic[1:0] jk_op_t {JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11}.
  - typedef enum seq_state_t {IDLE, ISSUE}.
  - Command struct {jk_op_t op; rpt}; CNT_W is a module parameter.
- Sub-module jk_cmd_fifo (parameterised by DEPTH and entry width): push/pop, full/empty, count.
- The FSM, counter and optional predictor stay in the top module.

Test Plan:
- Reset then push {SET, rpt=2} at E0 -> J/K=10 for exactly 3 cycles starting after E1; cmd_last high in the 3rd cycle; then J/K=00, busy=0.
- Push {SET,0}, {TOGGLE,3}, {RESET,1} back-to-back -> J/K sequence 10, 11,11,11,11, 01,01 with no 00 bubbles; cmd_last high on cycles 1, 5 and 7.
- Push 5 commands with DEPTH=4 while the sequencer is busy -> cmd_ready=0 once fifo_count=4; the 5th is held off and accepted only after a pop; no entry is lost or duplicated.
- Push {TOGGLE, rpt=15} (CNT_W=4) -> exactly 16 cycles of 11; the counter does not wrap past 0.
- Assert rst for 1 cycle in the middle of a TOGGLE run with 2 entries queued -> J/K=00, fifo_count=0 and cmd_ready=1 asynchronously; nothing plays afterwards.
- JK_PRED_EN defined, sequence SET,TOGGLE×3,HOLD×2,RESET -> q_pred: 1,0,1,0,0,0,0, matching the flip-flop's Q each cycle.
